// File: rtl/irb_pkg.sv
// Shared types for the IRB datapath: DMA command layout, opcodes and
// the arbiter state encoding.
package irb_pkg;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] info1;
      logic [31:0] mem_info1;
      logic [31:0] info2;
      logic [31:0] mem_info2;
   } dma_cmd_t;

   localparam logic [2:0] DMA_OP_INF = 3'd0;
   localparam logic [2:0] DMA_OP_FMI = 3'd1;
   localparam logic [2:0] DMA_OP_KEX = 3'd2;
   localparam logic [2:0] DMA_OP_KPW = 3'd3;
   localparam logic [2:0] DMA_OP_KDW = 3'd4;
   localparam logic [2:0] DMA_OP_FMO = 3'd5;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit strictly
// after 'last', wrapping modulo N_REQ.
module rr_pick #(
   parameter  int N_REQ = 3,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    sel,
   output logic             any
);

   logic [IW-1:0] idx;

   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = '0;
      // Farthest offset first, so the nearest requester after 'last' wins.
      for (int off = N_REQ; off >= 1; off--) begin
         idx = IW'((int'(last) + off) % N_REQ);
         if (req[idx]) begin
            sel = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_arbiter.sv
// Shares one DMA engine among N_REQ command sources: latches each start
// pulse's command, grants round-robin and routes f_dma back as req_done.
import irb_pkg::*;

module dma_arbiter #(
   parameter  int N_REQ = 3,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_start,
   input  dma_cmd_t [N_REQ-1:0] req_cmd,
   output logic [N_REQ-1:0]     req_done,
   output logic                 s_dma,
   output logic [2:0]           dma_op,
   output logic [31:0]          dma_info1,
   output logic [31:0]          dma_mem_info1,
   output logic [31:0]          dma_info2,
   output logic [31:0]          dma_mem_info2,
   input  logic                 f_dma,
   output logic                 busy,
   output logic [IW-1:0]        grant_id,
   output logic                 err_overrun,
   output logic                 err_spurious
);

   arb_state_e           state_q, state_d;
   logic [N_REQ-1:0]     pending_q, pending_d;
   dma_cmd_t [N_REQ-1:0] cmd_q, cmd_d;
   logic [IW-1:0]        last_q, last_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic                 s_dma_q, s_dma_d;
   logic [N_REQ-1:0]     done_q, done_d;
   dma_cmd_t             out_q, out_d;
   logic                 ovr_q, ovr_d;
   logic                 spur_q, spur_d;

   logic [IW-1:0]        pick_sel;
   logic                 pick_any;
   logic                 finish;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req  (pending_q),
      .last (last_q),
      .sel  (pick_sel),
      .any  (pick_any)
   );

   // The s_dma cycle is the first BUSY cycle; a finish there is too early to be real.
   assign finish = (state_q == ARB_BUSY) && !s_dma_q && f_dma;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cmd_d     = cmd_q;
      last_d    = last_q;
      grant_d   = grant_q;
      s_dma_d   = 1'b0;
      done_d    = '0;
      out_d     = out_q;
      ovr_d     = ovr_q;
      spur_d    = spur_q;

      case (state_q)
         ARB_IDLE: begin
            if (f_dma) spur_d = 1'b1;
            if (pick_any) begin
               out_d   = cmd_q[pick_sel];
               grant_d = pick_sel;
               s_dma_d = 1'b1;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (finish) begin
               done_d[grant_q]    = 1'b1;
               pending_d[grant_q] = 1'b0;
               last_d             = grant_q;
               state_d            = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      // Capture after the finish clear so a same-cycle restart wins.
      for (int i = 0; i < N_REQ; i++) begin
         if (req_start[i]) begin
            if ((finish && grant_q == IW'(i)) ||
                (!pending_q[i] && !(state_q == ARB_BUSY && grant_q == IW'(i)))) begin
               pending_d[i] = 1'b1;
               cmd_d[i]     = req_cmd[i];
            end else begin
               ovr_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         pending_q <= '0;
         cmd_q     <= '0;
         last_q    <= IW'(N_REQ - 1);
         grant_q   <= '0;
         s_dma_q   <= 1'b0;
         done_q    <= '0;
         out_q     <= '0;
         ovr_q     <= 1'b0;
         spur_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cmd_q     <= cmd_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         s_dma_q   <= s_dma_d;
         done_q    <= done_d;
         out_q     <= out_d;
         ovr_q     <= ovr_d;
         spur_q    <= spur_d;
      end
   end

   assign req_done      = done_q;
   assign s_dma         = s_dma_q;
   assign dma_op        = out_q.op;
   assign dma_info1     = out_q.info1;
   assign dma_mem_info1 = out_q.mem_info1;
   assign dma_info2     = out_q.info2;
   assign dma_mem_info2 = out_q.mem_info2;
   assign busy          = (state_q == ARB_BUSY);
   assign grant_id      = grant_q;
   assign err_overrun   = ovr_q;
   assign err_spurious  = spur_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model.
module tb_dma_arbiter;
   import irb_pkg::*;

   localparam int N = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req_start = '0;
   dma_cmd_t [N-1:0] req_cmd = '0;
   logic [N-1:0]     req_done;
   logic             s_dma;
   logic [2:0]       dma_op;
   logic [31:0]      dma_info1, dma_mem_info1, dma_info2, dma_mem_info2;
   logic             f_dma = 1'b0;
   logic             busy;
   logic [1:0]       grant_id;
   logic             err_overrun, err_spurious;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   dma_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .rst(rst), .req_start(req_start), .req_cmd(req_cmd),
      .req_done(req_done), .s_dma(s_dma), .dma_op(dma_op),
      .dma_info1(dma_info1), .dma_mem_info1(dma_mem_info1),
      .dma_info2(dma_info2), .dma_mem_info2(dma_mem_info2),
      .f_dma(f_dma), .busy(busy), .grant_id(grant_id),
      .err_overrun(err_overrun), .err_spurious(err_spurious)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic dma_cmd_t mk(input logic [2:0] op, input logic [31:0] a);
      dma_cmd_t c;
      c.op        = op;
      c.info1     = a;
      c.mem_info1 = a ^ 32'h1111_0000;
      c.info2     = a + 32'd1;
      c.mem_info2 = ~a;
      return c;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      req_start = '0;
      f_dma = 1'b0;
      #1;
      chk({tag, "_zero_ctl"}, {s_dma, req_done, busy, grant_id, err_overrun, err_spurious, dma_op}, 0);
      chk({tag, "_zero_i1"}, {dma_info1, dma_mem_info1}, 0);
      chk({tag, "_zero_i2"}, {dma_info2, dma_mem_info2}, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Bounded wait for the next s_dma; clears one-cycle input pulses.
   task automatic wait_sdma(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         req_start = '0;
         f_dma = 1'b0;
         if (s_dma) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("sdma_timeout", 0, 1);
   endtask

   // Serve one grant: finish 'lat' cycles after s_dma, check req_done.
   task automatic serve(input int lat, output int gid);
      bit ok;
      logic [N-1:0] expd;
      wait_sdma(ok);
      gid = int'(grant_id);
      repeat (lat) tick();
      f_dma = 1'b1;
      tick();
      f_dma = 1'b0;
      expd = '0;
      if (gid < N) expd[gid] = 1'b1;
      chk("serve_done", req_done, expd);
   endtask

   int            g;
   int            exp_fair[5] = '{0, 2, 0, 2, 0};
   int            last, owner, fcyc, sel;
   bit            idle_prev;
   bit            out_st[N];
   int            scyc[N];
   dma_cmd_t      mcmd[N];
   logic [N-1:0]  exp_done;

   initial begin
      #2;
      do_reset("rst0");

      // Single request, DMA finishes 10 cycles after s_dma
      req_cmd[1] = mk(3'd2, 32'd5);
      req_start = 3'b010;
      tick(); req_start = '0;
      chk("t1_c1_sdma", s_dma, 0);
      tick();
      chk("t1_c2_sdma", s_dma, 1);
      chk("t1_op", dma_op, 2);
      chk("t1_info1", dma_info1, 5);
      chk("t1_gid", grant_id, 1);
      chk("t1_busy", busy, 1);
      repeat (10) tick();
      chk("t1_pre_done", {req_done, busy}, 4'b0001);
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t1_done", req_done, 3'b010);
      chk("t1_idle", busy, 0);
      tick();
      chk("t1_done_pulse", req_done, 3'b000);

      // Simultaneous requests from reset, twice
      do_reset("rst1");
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < N; i++) req_cmd[i] = mk(3'(i), 32'(100 + i));
         req_start = 3'b111;
         for (int k = 0; k < N; k++) begin
            serve(3, g);
            chk("t2_order", g, k);
            chk("t2_op", dma_op, k);
         end
      end

      // Fairness: 0 and 2 re-request right after each own done
      req_cmd[0] = mk(DMA_OP_FMI, 32'h10);
      req_cmd[2] = mk(DMA_OP_FMO, 32'h12);
      req_start = 3'b101;
      for (int k = 0; k < 5; k++) begin
         serve(2, g);
         chk("t3_fair", g, exp_fair[k]);
         if (k < 3 && g < N) begin
            req_cmd[g] = mk(3'(g), 32'(200 + k));
            req_start[g] = 1'b1;
         end
      end

      // Overrun while pending: first command wins
      do_reset("rst2");
      req_cmd[0] = mk(3'd1, 32'hAA);
      req_start = 3'b001;
      tick();
      req_cmd[0] = mk(3'd5, 32'hBB);
      tick(); req_start = '0;
      chk("t4_sdma", s_dma, 1);
      chk("t4_op", dma_op, 1);
      chk("t4_info1", dma_info1, 32'hAA);
      chk("t4_ovr", err_overrun, 1);
      repeat (2) tick();
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t4_done", req_done, 3'b001);
      repeat (4) begin
         tick();
         chk("t4_no_regrant", {s_dma, busy}, 0);
      end

      // Same-cycle finish and restart of requester 0
      do_reset("rst3");
      req_cmd[0] = mk(3'd3, 32'hCC);
      req_start = 3'b001;
      tick(); req_start = '0;
      tick();
      chk("t5_sdma", s_dma, 1);
      repeat (3) tick();
      f_dma = 1'b1;
      req_cmd[0] = mk(3'd4, 32'hDD);
      req_start = 3'b001;
      tick(); f_dma = 1'b0; req_start = '0;
      chk("t5_done", req_done, 3'b001);
      chk("t5_no_ovr", err_overrun, 0);
      chk("t5_idle", busy, 0);
      tick();
      chk("t5_regrant", {s_dma, grant_id, dma_op}, {1'b1, 2'd0, 3'd4});
      chk("t5_info1", dma_info1, 32'hDD);
      tick();
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t5_done2", req_done, 3'b001);

      // Spurious finish in IDLE
      do_reset("rst4");
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t6_spur", err_spurious, 1);
      chk("t6_fsm", {busy, req_done, s_dma}, 0);
      req_cmd[1] = mk(3'd2, 32'h77);
      req_start = 3'b010;
      tick(); req_start = '0;
      tick();
      chk("t6_grant", {s_dma, grant_id}, {1'b1, 2'd1});

      // Finish in the s_dma cycle is ignored quietly
      do_reset("rst5");
      req_start = 3'b010;
      tick(); req_start = '0;
      tick();
      chk("t7_sdma", s_dma, 1);
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t7_no_spur", err_spurious, 0);
      chk("t7_still_busy", {busy, req_done}, 4'b1000);
      repeat (2) tick();
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t7_done", req_done, 3'b010);

      // Reset mid-BUSY with another request pending
      do_reset("rst6");
      req_start = 3'b011;
      tick(); req_start = '0;
      tick();
      chk("t8_sdma", {s_dma, grant_id}, {1'b1, 2'd0});
      tick();
      do_reset("t8_midbusy");
      for (int k = 0; k < 4; k++) begin
         chk("t8_discard", {req_done, s_dma, busy}, 0);
         tick();
      end
      req_cmd[2] = mk(3'd2, 32'hEE);
      req_start = 3'b100;
      tick(); req_start = '0;
      chk("t8_c1", s_dma, 0);
      tick();
      chk("t8_c2", {s_dma, grant_id}, {1'b1, 2'd2});
      chk("t8_info1", dma_info1, 32'hEE);
      tick();
      f_dma = 1'b1;
      tick(); f_dma = 1'b0;
      chk("t8_done", req_done, 3'b100);

      // Randomized run against a transaction-level model
      do_reset("rst7");
      last = N - 1;
      owner = -1;
      fcyc = -1;
      for (int i = 0; i < N; i++) begin
         out_st[i] = 1'b0;
         scyc[i] = 0;
         mcmd[i] = '0;
      end
      for (int c = 0; c < 3000; c++) begin
         exp_done = '0;
         if (owner >= 0 && fcyc == c - 1) exp_done[owner] = 1'b1;
         chk("r_done", req_done, exp_done);
         idle_prev = (owner < 0);
         if (exp_done != '0) begin
            out_st[owner] = 1'b0;
            last = owner;
            owner = -1;
         end
         // A start at cycle t can produce s_dma no earlier than t+2.
         sel = -1;
         if (idle_prev) begin
            for (int k = 1; k <= N; k++) begin
               if (sel < 0 && out_st[(last + k) % N] && scyc[(last + k) % N] <= c - 2)
                  sel = (last + k) % N;
            end
         end
         chk("r_sdma", s_dma, sel >= 0);
         if (sel >= 0) begin
            chk("r_gid", grant_id, sel);
            chk("r_cmd_a", {dma_op, dma_info1}, {mcmd[sel].op, mcmd[sel].info1});
            chk("r_cmd_b", {dma_mem_info1, dma_info2}, {mcmd[sel].mem_info1, mcmd[sel].info2});
            chk("r_cmd_c", dma_mem_info2, mcmd[sel].mem_info2);
            owner = sel;
            fcyc = c + int'($urandom_range(1, 6));
         end
         chk("r_busy", busy, owner >= 0);
         chk("r_err", {err_overrun, err_spurious}, 0);
         f_dma = (owner >= 0 && fcyc == c);
         for (int i = 0; i < N; i++) begin
            req_start[i] = 1'b0;
            req_cmd[i] = mk(3'($urandom), $urandom);
            if (!out_st[i] && $urandom_range(0, 3) == 0) begin
               mcmd[i] = req_cmd[i];
               req_start[i] = 1'b1;
               out_st[i] = 1'b1;
               scyc[i] = c;
            end
         end
         tick();
      end
      req_start = '0;
      f_dma = 1'b0;

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
